// File: rtl/tc_mul_pipe.sv
// Pipelined unsigned x signed multiplier with optional rounding shift,
// saturating or wrapping narrowing, per-result overflow flag and overflow counter.
module tc_mul_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 18,
  parameter int P_WIDTH   = 31,
  parameter int NUM_STAGE = 3,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 0,
  parameter int SATURATE  = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic        [A_WIDTH-1:0]   din0,
  input  logic signed [B_WIDTH-1:0]   din1,
  output logic                        out_valid,
  output logic signed [P_WIDTH-1:0]   dout,
  output logic                        ovf,
  input  logic                        clr_stat,
  output logic        [CNT_WIDTH-1:0] ovf_count
);

  localparam int PW  = A_WIDTH + B_WIDTH;
  localparam int SW  = PW + 1;
  localparam int MW  = ((SW > P_WIDTH) ? SW : P_WIDTH) + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [SW-1:0] RND  = (ROUND != 0 && SHIFT > 0) ? (SW'(1) <<< RSH) : '0;
  localparam logic signed [MW-1:0] MAXV = (MW'(1) <<< (P_WIDTH - 1)) - MW'(1);
  localparam logic signed [MW-1:0] MINV = -(MW'(1) <<< (P_WIDTH - 1));

  // Rounding add is done one bit wider than the product so it cannot overflow.
  function automatic logic signed [SW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [SW-1:0] s;
    s = {p[PW-1], p} + RND;
    return s >>> SHIFT;
  endfunction

  // Returns {overflow, narrowed result}.
  function automatic logic [P_WIDTH:0] narrow(input logic signed [SW-1:0] s);
    logic signed [MW-1:0] x;
    logic                 o;
    logic [P_WIDTH-1:0]   d;
    x = {{(MW - SW){s[SW-1]}}, s};
    o = (x > MAXV) || (x < MINV);
    if (SATURATE != 0 && o)
      d = (x < MINV) ? MINV[P_WIDTH-1:0] : MAXV[P_WIDTH-1:0];
    else
      d = x[P_WIDTH-1:0];
    return {o, d};
  endfunction

  logic        [A_WIDTH-1:0]   w_a;
  logic signed [B_WIDTH-1:0]   w_b;
  logic signed [PW-1:0]        w_a_x;
  logic signed [PW-1:0]        w_b_x;
  logic signed [PW-1:0]        w_prod;
  logic signed [PW-1:0]        w_prod_d;
  logic signed [SW-1:0]        w_sh;
  logic        [P_WIDTH:0]     w_nar;
  logic        [NUM_STAGE:0]   w_vchain;
  logic        [NUM_STAGE-1:0] r_vld_p;
  logic signed [P_WIDTH-1:0]   r_dout_p;
  logic                        r_ovf_p;
  logic        [CNT_WIDTH-1:0] r_cnt;

  // Stage 1: input registers (bypassed when the whole pipe is one stage)
  generate
    if (NUM_STAGE >= 2) begin : g_in
      logic        [A_WIDTH-1:0] r_a_p0;
      logic signed [B_WIDTH-1:0] r_b_p0;
      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          r_a_p0 <= '0;
          r_b_p0 <= '0;
        end else if (ce) begin
          r_a_p0 <= din0;
          r_b_p0 <= din1;
        end
      end
      assign w_a = r_a_p0;
      assign w_b = r_b_p0;
    end else begin : g_in_comb
      assign w_a = din0;
      assign w_b = din1;
    end
  endgenerate

  assign w_a_x  = {{B_WIDTH{1'b0}}, w_a};
  assign w_b_x  = {{A_WIDTH{w_b[B_WIDTH-1]}}, w_b};
  assign w_prod = w_a_x * w_b_x;

  // Middle stages: registered exact product, delayed to fill the pipe depth
  generate
    if (NUM_STAGE >= 3) begin : g_mul
      logic signed [PW-1:0] r_prod_p1 [NUM_STAGE-2];
      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          for (int i = 0; i < NUM_STAGE - 2; i++) r_prod_p1[i] <= '0;
        end else if (ce) begin
          r_prod_p1[0] <= w_prod;
          for (int i = 1; i < NUM_STAGE - 2; i++) r_prod_p1[i] <= r_prod_p1[i-1];
        end
      end
      assign w_prod_d = r_prod_p1[NUM_STAGE-3];
    end else begin : g_mul_comb
      assign w_prod_d = w_prod;
    end
  endgenerate

  assign w_sh  = round_shift(w_prod_d);
  assign w_nar = narrow(w_sh);

  assign w_vchain = {r_vld_p, in_valid};

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_vld_p <= '0;
    else if (ce) r_vld_p <= w_vchain[NUM_STAGE-1:0];
  end

  // Last stage: round, shift and narrow result
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_dout_p <= '0;
      r_ovf_p  <= 1'b0;
    end else if (ce && w_vchain[NUM_STAGE-1]) begin
      r_dout_p <= w_nar[P_WIDTH-1:0];
      r_ovf_p  <= w_nar[P_WIDTH];
    end
  end

  // Counter steps on the same edge the overflowing result is emitted.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_cnt <= '0;
    else if (clr_stat) r_cnt <= '0;
    else if (ce && w_vchain[NUM_STAGE-1] && w_nar[P_WIDTH] && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end

  assign out_valid = w_vchain[NUM_STAGE];
  assign dout      = r_dout_p;
  assign ovf       = r_ovf_p;
  assign ovf_count = r_cnt;

endmodule

// File: tb/tb_tc_mul_pipe.sv
// Directed bench for tc_mul_pipe: four parameterisations share one stimulus bus.
module tb_tc_mul_pipe;

  logic               clk = 1'b0;
  logic               ap_rst;
  logic               ce;
  logic               in_valid;
  logic [15:0]        din0;
  logic signed [17:0] din1;
  logic               clr_stat;

  logic               v0, v1, v2, v3;
  logic signed [30:0] d0, d1, d2, d3;
  logic               o0, o1, o2, o3;
  logic [15:0]        c0, c1, c2;
  logic [1:0]         c3;

  int                 n_chk = 0;
  int                 n_err = 0;
  int                 sel;

  logic               s_vld;
  logic signed [30:0] s_dout;
  logic               s_ovf;
  logic [15:0]        s_cnt;

  typedef struct {
    bit     v;
    int     a;
    int     b;
    longint exp;
    bit     o;
    int     cnt;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  tc_mul_pipe u0 (.ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
                  .out_valid(v0), .dout(d0), .ovf(o0), .clr_stat(clr_stat), .ovf_count(c0));
  tc_mul_pipe #(.SATURATE(1)) u1 (.ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0),
                  .din1(din1), .out_valid(v1), .dout(d1), .ovf(o1), .clr_stat(clr_stat), .ovf_count(c1));
  tc_mul_pipe #(.SHIFT(4), .ROUND(1)) u2 (.ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0),
                  .din1(din1), .out_valid(v2), .dout(d2), .ovf(o2), .clr_stat(clr_stat), .ovf_count(c2));
  tc_mul_pipe #(.CNT_WIDTH(2)) u3 (.ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0),
                  .din1(din1), .out_valid(v3), .dout(d3), .ovf(o3), .clr_stat(clr_stat), .ovf_count(c3));

  always_comb begin
    s_vld  = v0;
    s_dout = d0;
    s_ovf  = o0;
    s_cnt  = c0;
    case (sel)
      1: begin s_vld = v1; s_dout = d1; s_ovf = o1; s_cnt = c1; end
      2: begin s_vld = v2; s_dout = d2; s_ovf = o2; s_cnt = c2; end
      3: begin s_vld = v3; s_dout = d3; s_ovf = o3; s_cnt = {14'b0, c3}; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vector c is presented before edge c and is expected out after edge c+2.
  task automatic run_stream(input string tag);
    for (int c = 0; c < vq.size() + 2; c++) begin
      if (c < vq.size()) begin
        in_valid = vq[c].v;
        din0     = 16'(vq[c].a);
        din1     = 18'(vq[c].b);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 2) begin
        chk($sformatf("%s[%0d].vld", tag, c - 2), s_vld, vq[c-2].v);
        if (vq[c-2].v) begin
          chk($sformatf("%s[%0d].dout", tag, c - 2), s_dout, vq[c-2].exp);
          chk($sformatf("%s[%0d].ovf", tag, c - 2), s_ovf, vq[c-2].o);
        end
        if (vq[c-2].cnt >= 0)
          chk($sformatf("%s[%0d].cnt", tag, c - 2), s_cnt, vq[c-2].cnt);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    ap_rst = 1'b1; ce = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0; clr_stat = 1'b0; sel = 0;
    tick(); tick();
    chk("rst.vld", v0, 0);
    chk("rst.dout", d0, 0);
    chk("rst.ovf", o0, 0);
    chk("rst.cnt", c0, 0);
    ap_rst = 1'b0;
    tick();

    // Most negative product: wraps on u0, clamps on u1
    sel = 0;
    vq = '{'{1, 65535, -131072, 131072, 1, 1}};
    run_stream("wrap");
    chk("sat.vld", v1, 1);
    chk("sat.dout", d1, -1073741824);
    chk("sat.ovf", o1, 1);
    chk("sat.cnt", c1, 1);
    chk("cnt2.first", c3, 1);
    tick();

    // Rounding shift by 4
    sel = 2;
    vq = '{'{1, 3, -5, -1, 0, -1}, '{1, 3, 5, 1, 0, -1}, '{1, 8, 1, 1, 0, -1},
           '{1, 7, 1, 0, 0, -1}, '{1, 0, -131072, 0, 0, -1}};
    run_stream("rnd");

    // Stream with bubbles: din0=i, din1=i-5
    sel = 0;
    vq = '{'{1, 0, -5, 0, 0, -1}, '{1, 1, -4, -4, 0, -1}, '{0, 2, -3, -6, 0, -1},
           '{1, 3, -2, -6, 0, -1}, '{1, 4, -1, -4, 0, -1}, '{0, 5, 0, 0, 0, -1},
           '{1, 6, 1, 6, 0, -1}, '{1, 7, 2, 14, 0, -1}, '{0, 8, 3, 24, 0, -1},
           '{1, 9, 4, 36, 0, 1}};
    run_stream("strm");

    // Clock-enable stall with results in flight
    in_valid = 1'b1; din0 = 16'd10; din1 = 18'sd2; tick();
    din0 = 16'd11; din1 = 18'sd3; tick();
    din0 = 16'd12; din1 = 18'sd4; tick();
    chk("ce.pre.vld", v0, 1);
    chk("ce.pre.dout", d0, 20);
    ce = 1'b0; din0 = 16'd99; din1 = 18'sd99;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ce.hold%0d.vld", k), v0, 1);
      chk($sformatf("ce.hold%0d.dout", k), d0, 20);
    end
    ce = 1'b1; in_valid = 1'b0;
    tick();
    chk("ce.r1.vld", v0, 1);
    chk("ce.r1.dout", d0, 33);
    tick();
    chk("ce.r2.vld", v0, 1);
    chk("ce.r2.dout", d0, 48);
    tick();
    chk("ce.r3.vld", v0, 0);

    // Asynchronous reset with work in flight
    in_valid = 1'b1; din0 = 16'd1; din1 = 18'sd1; tick();
    din0 = 16'd2; din1 = 18'sd2; tick();
    din0 = 16'd3; din1 = 18'sd3; tick();
    chk("arst.pre.dout", d0, 1);
    in_valid = 1'b0;
    #3 ap_rst = 1'b1;
    #1;
    chk("arst.vld", v0, 0);
    chk("arst.dout", d0, 0);
    chk("arst.cnt", c0, 0);
    chk("arst.sat.dout", d1, 0);
    #2 ap_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("arst.post%0d.vld", k), v0, 0);
    end

    // Two-bit saturating overflow counter and clear priority
    sel = 3;
    vq = '{'{1, 65535, -131072, 131072, 1, 1}, '{1, 65535, -131072, 131072, 1, 2},
           '{1, 65535, -131072, 131072, 1, 3}, '{1, 65535, -131072, 131072, 1, 3},
           '{1, 65535, -131072, 131072, 1, 3}};
    run_stream("cnt");
    in_valid = 1'b1; din0 = 16'd65535; din1 = -18'sd131072; tick();
    in_valid = 1'b0; tick();
    clr_stat = 1'b1; tick();
    chk("clr.vld", v3, 1);
    chk("clr.ovf", o3, 1);
    chk("clr.cnt", c3, 0);
    clr_stat = 1'b0; tick();
    chk("clr.after", c3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tc_mul_pipe.md
Name: tc_mul_pipe

Overview:
- Parametrised, pipelined unsigned×signed multiplier for the TrackletCalculator datapath; successor to the fixed 16ns×18s→31 single-cycle multiply.
- Adds configurable operand and result widths, a pipeline depth with a valid/clock-enable stall, an optional rounding right-shift, and saturating or wrapping narrowing.
- Reports an overflow flag per result and keeps a sticky overflow counter for monitoring.

Parameters:
- A_WIDTH, 16, width of unsigned operand din0
- B_WIDTH, 18, width of signed operand din1
- P_WIDTH, 31, width of signed result dout
- NUM_STAGE, 3, pipeline latency in enabled cycles (legal range 1–8)
- SHIFT, 0, arithmetic right shift applied to the full product (legal range 0–A_WIDTH+B_WIDTH-1)
- ROUND, 0, 1 means add 2^(SHIFT-1) before the shift (round half up); ignored when SHIFT=0
- SATURATE, 0, 1 means clamp to the P_WIDTH signed range; 0 means keep the low P_WIDTH bits (wrap)
- CNT_WIDTH, 16, width of the overflow counter

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; low freezes the entire pipeline
- in_valid  in  1  din0/din1 carry an operand pair
- din0  in  A_WIDTH  unsigned multiplicand
- din1  in  B_WIDTH  signed multiplier
- out_valid  out  1  dout/ovf valid
- dout  out  P_WIDTH  signed result
- ovf  out  1  the result exceeded the P_WIDTH signed range before narrowing
- clr_stat  in  1  synchronous clear of ovf_count
- ovf_count  out  CNT_WIDTH  count of valid results with ovf=1; saturates at all-ones

Behaviour:
- Reset (async assert, sync release) clears out_valid, dout, ovf, ovf_count and every internal valid and data stage to 0. Work in flight is discarded. There is no output activity until new inputs arrive after release.
- Full product: prod = zero-extended din0 × din1, signed, A_WIDTH+B_WIDTH bits. The product is exact and never truncated.
- Shift step: sh = (prod + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed at A_WIDTH+B_WIDTH+1 bits so the rounding add cannot overflow.
- ovf = 1 when sh < -2^(P_WIDTH-1) or sh > 2^(P_WIDTH-1)-1. The flag is reported in both wrap and saturate modes.
- Narrowing:
  - SATURATE=1: dout = clamp(sh).
  - SATURATE=0: dout = sh[P_WIDTH-1:0].
- Latency: an operand pair sampled on a cycle with ce=1 and in_valid=1 appears on out_valid/dout/ovf exactly NUM_STAGE ce=1 cycles later. Throughput is one result per enabled cycle.
- Stage split (internal, fixed):
  - Stage 1 registers the inputs.
  - The multiply is registered in the middle stages.
  - The last stage registers the round, shift and narrow result.
  - For NUM_STAGE=1 everything runs in one registered stage.
- Valid bits travel alongside the data in a NUM_STAGE-deep shift register.
- Data registers of invalid slots may hold stale values. dout holds its last value while out_valid=0.
- ce=0: no register updates, including the valid chain and ovf_count. out_valid/dout/ovf hold. Inputs are ignored.
- ovf_count increments by 1 on each ce=1 cycle where the result being emitted has out_valid=1 and ovf=1. It stops at 2^CNT_WIDTH-1.
- clr_stat=1 zeroes ovf_count on the next edge regardless of ce, and takes priority over a simultaneous increment.
- Boundaries:
  - din1 = -2^(B_WIDTH-1) with din0 = 2^A_WIDTH-1 is the most negative product and must be exact.
  - din0=0 gives 0 with ovf=0.
  - in_valid=0 bubbles propagate as out_valid=0 at the same latency.

Test Plan:
- Defaults, din0=65535, din1=-131072 → 3 cycles later: out_valid=1, dout=131072 (wrapped), ovf=1, ovf_count=1. Same with SATURATE=1 → dout=-1073741824, ovf=1.
- SHIFT=4, ROUND=1:
  - (3,-5) → dout=-1
  - (3,5) → dout=1
  - (8,1) → dout=1 (half up)
  - (7,1) → dout=0
  - all with ovf=0.
- Back-to-back stream of 10 pairs, din0=i, din1=i-5, with in_valid toggled 1,1,0,1,... → outputs i·(i-5) in order, bubbles preserved, each at latency 3.
- ce held low for 4 cycles mid-stream → out_valid/dout frozen; results resume in order with no loss or duplication.
- ap_rst pulsed asynchronously with 2 results in flight → all outputs 0 immediately; no stale out_valid after release.
- CNT_WIDTH=2, 5 overflowing results → ovf_count 1,2,3,3,3. clr_stat asserted on the same cycle as an overflow → ovf_count=0.
